// File: rtl/hex_entry_32_pkg.sv
// Shared constants and types for the 8-digit hex entry block and its display path.
// The debounce counter width is derived from the debounce period by debounce_width().
package hex_entry_32_pkg;

    localparam int NIBBLE_W = 4;
    localparam int DIGITS   = 8;
    localparam int DATA_W   = NIBBLE_W * DIGITS;
    localparam int COUNT_W  = 4;

    // Counter must be able to hold DEBOUNCE_CLOCKS itself.
    function automatic int debounce_width(input int clocks);
        return $clog2(clocks + 1);
    endfunction

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_PUSH,
        ACT_BACK,
        ACT_CLEAR
    } action_e;

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-flop synchronizer, saturating-window debouncer and a
// registered one-cycle pulse on each debounced rising edge.
module btn_debounce
    import hex_entry_32_pkg::*;
#(
    parameter int DEBOUNCE_CLOCKS = 100_000
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CNT_W = debounce_width(DEBOUNCE_CLOCKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CLOCKS - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             level_q;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pulse_q;

    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // blocking assignments would let sync_q2 see this cycle's sync_q1.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q1      <= 1'b0;
            sync_q2      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
            pulse_q      <= 1'b0;
        end else begin
            sync_q1      <= btn_i;
            sync_q2      <= sync_q1;
            level_prev_q <= level_q;
            pulse_q      <= level_q & ~level_prev_q;

            // The count that would reach DEBOUNCE_CLOCKS flips the level instead.
            if (sync_q2 == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= ~level_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/hex_entry_32.sv
// Hex digit entry register: push/back/clear buttons edit up to eight nibbles,
// newest nibble in data_o[3:0], with a one-cycle changed_o strobe.
module hex_entry_32
    import hex_entry_32_pkg::*;
#(
    parameter int DEBOUNCE_CLOCKS = 100_000
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic [NIBBLE_W-1:0] sw_i,
    input  logic              btn_push_i,
    input  logic              btn_back_i,
    input  logic              btn_clr_i,
    output logic [DATA_W-1:0] data_o,
    output logic [COUNT_W-1:0] count_o,
    output logic              changed_o
);

    localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(DIGITS);

    logic push_pulse;
    logic back_pulse;
    logic clr_pulse;

    btn_debounce #(.DEBOUNCE_CLOCKS(DEBOUNCE_CLOCKS)) u_push (
        .clk     (clk),
        .rst_ni  (rst_ni),
        .btn_i   (btn_push_i),
        .pulse_o (push_pulse)
    );

    btn_debounce #(.DEBOUNCE_CLOCKS(DEBOUNCE_CLOCKS)) u_back (
        .clk     (clk),
        .rst_ni  (rst_ni),
        .btn_i   (btn_back_i),
        .pulse_o (back_pulse)
    );

    btn_debounce #(.DEBOUNCE_CLOCKS(DEBOUNCE_CLOCKS)) u_clr (
        .clk     (clk),
        .rst_ni  (rst_ni),
        .btn_i   (btn_clr_i),
        .pulse_o (clr_pulse)
    );

    action_e action;

    // NOTE: action gets its default before any condition so this block can
    // never infer a latch when no button pulses.
    always_comb begin
        action = ACT_NONE;
        if (clr_pulse) begin
            action = ACT_CLEAR;
        end else if (back_pulse) begin
            action = ACT_BACK;
        end else if (push_pulse) begin
            action = ACT_PUSH;
        end
    end

    logic [DATA_W-1:0]  data_q;
    logic [COUNT_W-1:0] count_q;
    logic               changed_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q    <= '0;
            count_q   <= '0;
            changed_q <= 1'b0;
        end else begin
            changed_q <= 1'b0;
            unique case (action)
                ACT_CLEAR: begin
                    data_q    <= '0;
                    count_q   <= '0;
                    changed_q <= 1'b1;
                end
                ACT_BACK: begin
                    // Backspace on an empty entry is silently ignored.
                    if (count_q != '0) begin
                        data_q    <= {{NIBBLE_W{1'b0}}, data_q[DATA_W-1:NIBBLE_W]};
                        count_q   <= count_q - 1'b1;
                        changed_q <= 1'b1;
                    end
                end
                ACT_PUSH: begin
                    data_q    <= {data_q[DATA_W-NIBBLE_W-1:0], sw_i};
                    changed_q <= 1'b1;
                    if (count_q != COUNT_FULL) begin
                        count_q <= count_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_o    = data_q;
    assign count_o   = count_q;
    assign changed_o = changed_q;

endmodule

// File: tb/tb_hex_entry_32.sv
// Directed bench for hex_entry_32 with a 4-clock debounce window.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_hex_entry_32;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic [3:0]  sw_i = 4'h0;
    logic        btn_push_i = 1'b0;
    logic        btn_back_i = 1'b0;
    logic        btn_clr_i = 1'b0;
    logic [31:0] data_o;
    logic [3:0]  count_o;
    logic        changed_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hex_entry_32 #(.DEBOUNCE_CLOCKS(N)) dut (
        .clk        (clk),
        .rst_ni     (rst_ni),
        .sw_i       (sw_i),
        .btn_push_i (btn_push_i),
        .btn_back_i (btn_back_i),
        .btn_clr_i  (btn_clr_i),
        .data_o     (data_o),
        .count_o    (count_o),
        .changed_o  (changed_o)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_all();
        btn_push_i = 1'b0;
        btn_back_i = 1'b0;
        btn_clr_i  = 1'b0;
    endtask

    task automatic do_reset();
        release_all();
        rst_ni = 1'b0;
        tick(2);
        rst_ni = 1'b1;
        tick(1);
    endtask

    // Holds the chosen buttons for `hold` cycles, releases them for 12 cycles,
    // and counts changed_o strobes over the whole window.
    task automatic press(input logic clr, input logic back, input logic push,
                         input logic [3:0] nib, input int hold, output int pulses);
        pulses     = 0;
        sw_i       = nib;
        btn_clr_i  = clr;
        btn_back_i = back;
        btn_push_i = push;
        for (int i = 0; i < hold; i++) begin
            tick(1);
            if (changed_o) pulses++;
        end
        release_all();
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (changed_o) pulses++;
        end
    endtask

    task automatic test_reset();
        #2 rst_ni = 1'b0;
        #1;
        total++;
        if (data_o !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=%h", data_o, 32'h0); end
        total++;
        if (count_o !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count_o); end
        total++;
        if (changed_o !== 1'b0) begin bad++; $display("FAIL reset_changed got=%b want=0", changed_o); end
        tick(2);
        rst_ni = 1'b1;
        tick(1);
    endtask

    task automatic test_first_push();
        int pulses;
        do_reset();
        pulses = 0;
        sw_i = 4'hA;
        btn_push_i = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick(1);
            if (changed_o) pulses++;
            if (e == 7) begin
                total++;
                if (count_o !== 4'd0) begin bad++; $display("FAIL first_push_early got=%0d want=0", count_o); end
            end
            if (e == 8) begin
                total++;
                if (data_o !== 32'h0000000A) begin bad++; $display("FAIL first_push_data got=%h want=%h", data_o, 32'h0000000A); end
                total++;
                if (count_o !== 4'd1) begin bad++; $display("FAIL first_push_count got=%0d want=1", count_o); end
                total++;
                if (changed_o !== 1'b1) begin bad++; $display("FAIL first_push_changed got=%b want=1", changed_o); end
            end
        end
        release_all();
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (changed_o) pulses++;
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL first_push_pulses got=%0d want=1", pulses); end
    endtask

    task automatic test_overflow();
        int pulses;
        do_reset();
        for (int v = 1; v <= 8; v++) press(1'b0, 1'b0, 1'b1, 4'(v), 10, pulses);
        total++;
        if (data_o !== 32'h12345678 || count_o !== 4'd8) begin
            bad++; $display("FAIL full_entry got=%h/%0d want=12345678/8", data_o, count_o);
        end
        press(1'b0, 1'b0, 1'b1, 4'h9, 10, pulses);
        total++;
        if (data_o !== 32'h23456789 || count_o !== 4'd8) begin
            bad++; $display("FAIL overflow_entry got=%h/%0d want=23456789/8", data_o, count_o);
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL overflow_pulses got=%0d want=1", pulses); end
    endtask

    task automatic test_back();
        int pulses;
        do_reset();
        for (int v = 1; v <= 3; v++) press(1'b0, 1'b0, 1'b1, 4'(v), 10, pulses);
        press(1'b0, 1'b1, 1'b0, 4'h0, 10, pulses);
        total++;
        if (data_o !== 32'h00000012 || count_o !== 4'd2 || pulses != 1) begin
            bad++; $display("FAIL back_one got=%h/%0d/%0d want=00000012/2/1", data_o, count_o, pulses);
        end
        press(1'b0, 1'b1, 1'b0, 4'h0, 10, pulses);
        press(1'b0, 1'b1, 1'b0, 4'h0, 10, pulses);
        total++;
        if (data_o !== 32'h0 || count_o !== 4'd0 || pulses != 1) begin
            bad++; $display("FAIL back_to_empty got=%h/%0d/%0d want=00000000/0/1", data_o, count_o, pulses);
        end
        press(1'b0, 1'b1, 1'b0, 4'h0, 10, pulses);
        total++;
        if (data_o !== 32'h0 || count_o !== 4'd0 || pulses != 0) begin
            bad++; $display("FAIL back_on_empty got=%h/%0d/%0d want=00000000/0/0", data_o, count_o, pulses);
        end
    endtask

    task automatic test_glitch_bounce();
        int pulses;
        do_reset();
        press(1'b0, 1'b0, 1'b1, 4'h3, 3, pulses);
        total++;
        if (pulses != 0 || count_o !== 4'd0) begin
            bad++; $display("FAIL glitch_3 got=%0d/%0d want=0/0", pulses, count_o);
        end
        press(1'b0, 1'b0, 1'b1, 4'h4, 4, pulses);
        total++;
        if (pulses != 1 || data_o !== 32'h00000004) begin
            bad++; $display("FAIL pulse_4 got=%0d/%h want=1/00000004", pulses, data_o);
        end
        do_reset();
        pulses = 0;
        sw_i = 4'h5;
        for (int i = 0; i < 20; i++) begin
            btn_push_i = ((i / 2) % 2 == 0);
            tick(1);
            if (changed_o) pulses++;
        end
        total++;
        if (pulses != 0) begin bad++; $display("FAIL bounce_quiet got=%0d want=0", pulses); end
        press(1'b0, 1'b0, 1'b1, 4'h5, 15, pulses);
        total++;
        if (pulses != 1 || data_o !== 32'h00000005 || count_o !== 4'd1) begin
            bad++; $display("FAIL bounce_settle got=%0d/%h/%0d want=1/00000005/1", pulses, data_o, count_o);
        end
    endtask

    task automatic test_priority();
        int pulses;
        do_reset();
        press(1'b0, 1'b0, 1'b1, 4'h7, 10, pulses);
        press(1'b1, 1'b0, 1'b1, 4'h6, 10, pulses);
        total++;
        if (data_o !== 32'h0 || count_o !== 4'd0 || pulses != 1) begin
            bad++; $display("FAIL clr_push got=%h/%0d/%0d want=00000000/0/1", data_o, count_o, pulses);
        end
        press(1'b1, 1'b0, 1'b0, 4'h6, 10, pulses);
        total++;
        if (pulses != 1) begin bad++; $display("FAIL clr_when_empty got=%0d want=1", pulses); end
        press(1'b0, 1'b0, 1'b1, 4'h3, 10, pulses);
        press(1'b0, 1'b1, 1'b1, 4'hE, 10, pulses);
        total++;
        if (data_o !== 32'h0 || count_o !== 4'd0 || pulses != 1) begin
            bad++; $display("FAIL back_push got=%h/%0d/%0d want=00000000/0/1", data_o, count_o, pulses);
        end
    endtask

    task automatic test_async_reset();
        int pulses;
        do_reset();
        press(1'b0, 1'b0, 1'b1, 4'h1, 10, pulses);
        sw_i = 4'h9;
        btn_push_i = 1'b1;
        tick(4);
        #2 rst_ni = 1'b0;
        #1;
        total++;
        if (data_o !== 32'h0 || count_o !== 4'd0 || changed_o !== 1'b0) begin
            bad++; $display("FAIL async_reset got=%h/%0d/%b want=00000000/0/0", data_o, count_o, changed_o);
        end
        tick(1);
        rst_ni = 1'b1;
        pulses = 0;
        for (int e = 1; e <= 20; e++) begin
            tick(1);
            if (changed_o) pulses++;
            if (e == 7) begin
                total++;
                if (count_o !== 4'd0) begin bad++; $display("FAIL held_reset_early got=%0d want=0", count_o); end
            end
            if (e == 8) begin
                total++;
                if (data_o !== 32'h00000009 || count_o !== 4'd1) begin
                    bad++; $display("FAIL held_reset_push got=%h/%0d want=00000009/1", data_o, count_o);
                end
            end
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL held_reset_pulses got=%0d want=1", pulses); end
        release_all();
        tick(12);
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_overflow();
        test_back();
        test_glitch_bounce();
        test_priority();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
